// File: rtl/inst_sram_resp.sv
// Instruction SRAM responder: accepts requests onto a synchronous RAM and
// returns one in-order response per accepted request after LAT cycles.
module inst_sram_resp #(
    parameter int DEPTH = 2,
    parameter int LAT   = 2,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          wr,
    input  logic [1:0]    size,
    input  logic [3:0]    wstrb,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output logic          addr_ok,
    output logic          data_ok,
    output logic [31:0]   rdata,
    input  logic          stall,
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [1:0]    T_INIT = 2'(LAT - 1);

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ent_wr   [DEPTH];
    logic [1:0]    r_ent_tmr  [DEPTH];
    logic [31:0]   r_ent_data [DEPTH];
    logic          r_cap_v;
    logic [PW-1:0] r_cap_idx;

    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_head_data;
    logic          w_unused_bits;

    // Occupancy uses the registered count only, so a same-cycle pop never frees a slot.
    assign addr_ok = ~reset & req & ~stall & (r_count < FULL);
    assign data_ok = ~reset & (r_count != '0) & (r_ent_tmr[r_rptr] == 2'd0);
    assign w_push  = addr_ok;
    assign w_pop   = data_ok;

    assign mem_en    = w_push;
    assign mem_we    = (w_push & wr) ? wstrb : 4'b0000;
    assign mem_addr  = addr[AW+1:2];
    assign mem_wdata = wdata;

    // With LAT=1 the response coincides with the RAM read-data cycle, so bypass.
    assign w_head_data = (LAT == 1) ? mem_rdata : r_ent_data[r_rptr];
    assign rdata       = (data_ok & ~r_ent_wr[r_rptr]) ? w_head_data : '0;

    assign w_unused_bits = ^{size, addr[31:AW+2], addr[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_cap_v   <= 1'b0;
            r_cap_idx <= '0;
        end else begin
            r_cap_v   <= w_push;
            r_cap_idx <= r_wptr;
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_ent_wr[i]  <= 1'b0;
                r_ent_tmr[i] <= 2'd0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (w_push && (r_wptr == PW'(i))) begin
                    r_ent_wr[i]  <= wr;
                    r_ent_tmr[i] <= T_INIT;
                end else if (r_ent_tmr[i] != 2'd0) begin
                    r_ent_tmr[i] <= r_ent_tmr[i] - 2'd1;
                end
            end
        end
    end

    // Read data arrives one cycle after acceptance; file it into the slot it was pushed to.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (r_cap_v && (r_cap_idx == PW'(i))) begin
                r_ent_data[i] <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_inst_sram_resp.sv
// Directed and randomized checks of inst_sram_resp with LAT=2 and LAT=1 instances
// sharing one stimulus stream, each with its own behavioural RAM.
module tb_inst_sram_resp;

    logic        clk;
    logic        reset;
    logic        preload;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;

    logic        addr_ok0, data_ok0, mem_en0;
    logic [31:0] rdata0, mem_wdata0, mem_rdata0;
    logic [3:0]  mem_we0;
    logic [11:0] mem_addr0;

    logic        addr_ok1, data_ok1, mem_en1;
    logic [31:0] rdata1, mem_wdata1, mem_rdata1;
    logic [3:0]  mem_we1;
    logic [11:0] mem_addr1;

    logic [31:0] ram0 [4096];
    logic [31:0] ram1 [4096];
    logic [31:0] refmem [16];
    logic [31:0] sb [$];

    int total = 0;
    int bad   = 0;
    int acc;
    int cyc;
    int outstanding;
    logic [31:0] a_rand;
    logic [31:0] w_rand;
    logic [31:0] exp_val;

    inst_sram_resp #(.DEPTH(2), .LAT(2), .AW(12)) dut (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .addr_ok(addr_ok0), .data_ok(data_ok0),
        .rdata(rdata0), .stall(stall), .mem_en(mem_en0), .mem_we(mem_we0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
    );

    inst_sram_resp #(.DEPTH(2), .LAT(1), .AW(12)) dut1 (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .addr_ok(addr_ok1), .data_ok(data_ok1),
        .rdata(rdata1), .stall(stall), .mem_en(mem_en1), .mem_we(mem_we1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            ram0[0] <= 32'h11111111; ram1[0] <= 32'h11111111;
            ram0[1] <= 32'h22222222; ram1[1] <= 32'h22222222;
            ram0[2] <= 32'hAAAAAAAA; ram1[2] <= 32'hAAAAAAAA;
            ram0[3] <= 32'h44444444; ram1[3] <= 32'h44444444;
            ram0[5] <= 32'hDEADBEEF; ram1[5] <= 32'hDEADBEEF;
        end else begin
            if (mem_en0) begin
                mem_rdata0 <= ram0[mem_addr0];
                for (int b = 0; b < 4; b++)
                    if (mem_we0[b]) ram0[mem_addr0][8*b +: 8] <= mem_wdata0[8*b +: 8];
            end
            if (mem_en1) begin
                mem_rdata1 <= ram1[mem_addr1];
                for (int b = 0; b < 4; b++)
                    if (mem_we1[b]) ram1[mem_addr1][8*b +: 8] <= mem_wdata1[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic rq, input logic w, input logic [31:0] a,
                        input logic [3:0] st, input logic [31:0] wd);
        @(posedge clk);
        #1;
        req = rq; wr = w; addr = a; wstrb = st; wdata = wd;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; preload = 1'b1; req = 1'b1; wr = 1'b0; size = 2'b10;
        wstrb = 4'h0; addr = 32'h0; wdata = 32'h0; stall = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_addr_ok", addr_ok0, 0);
        chk("rst_data_ok", data_ok0, 0);
        chk("rst_rdata",   rdata0,   0);
        chk("rst_mem_en",  mem_en0,  0);
        chk("rst_mem_we",  mem_we0,  0);
        chk("rst_addr_ok1", addr_ok1, 0);
        @(posedge clk);
        #1;
        reset = 1'b0; preload = 1'b0; req = 1'b0;

        // Single read, LAT=2 timing
        tick(1, 0, 32'h1C000014, 4'h0, 32'h0);
        chk("rd_addr_ok", addr_ok0, 1);
        chk("rd_mem_en", mem_en0, 1);
        chk("rd_mem_addr", mem_addr0, 12'h005);
        chk("rd_mem_we", mem_we0, 0);
        tick(0, 0, 32'h0, 4'h0, 32'h0);
        chk("rd_t1_data_ok", data_ok0, 0);
        chk("l1_t1_data_ok", data_ok1, 1);
        chk("l1_t1_rdata", rdata1, 32'hDEADBEEF);
        tick(0, 0, 32'h0, 4'h0, 32'h0);
        chk("rd_t2_data_ok", data_ok0, 1);
        chk("rd_t2_rdata", rdata0, 32'hDEADBEEF);
        tick(0, 0, 32'h0, 4'h0, 32'h0);
        chk("rd_t3_data_ok", data_ok0, 0);
        chk("rd_t3_rdata", rdata0, 0);

        // Back-to-back reads: DEPTH=2 back-pressure on dut, LAT=1 streaming on dut1
        tick(1, 0, 32'h00000000, 4'h0, 32'h0);
        chk("bb_c0_addr_ok", addr_ok0, 1);
        chk("bb_c0_addr_ok1", addr_ok1, 1);
        tick(1, 0, 32'h00000004, 4'h0, 32'h0);
        chk("bb_c1_addr_ok", addr_ok0, 1);
        chk("bb_c1_data_ok1", data_ok1, 1);
        chk("bb_c1_rdata1", rdata1, 32'h11111111);
        tick(1, 0, 32'h00000008, 4'h0, 32'h0);
        chk("bb_c2_addr_ok", addr_ok0, 0);
        chk("bb_c2_mem_en", mem_en0, 0);
        chk("bb_c2_data_ok", data_ok0, 1);
        chk("bb_c2_rdata", rdata0, 32'h11111111);
        chk("bb_c2_rdata1", rdata1, 32'h22222222);
        tick(1, 0, 32'h0000000C, 4'h0, 32'h0);
        chk("bb_c3_addr_ok", addr_ok0, 1);
        chk("bb_c3_data_ok", data_ok0, 1);
        chk("bb_c3_rdata", rdata0, 32'h22222222);
        chk("bb_c3_rdata1", rdata1, 32'hAAAAAAAA);
        tick(0, 0, 32'h0, 4'h0, 32'h0);
        chk("bb_c4_data_ok", data_ok0, 0);
        chk("bb_c4_data_ok1", data_ok1, 1);
        chk("bb_c4_rdata1", rdata1, 32'h44444444);
        tick(0, 0, 32'h0, 4'h0, 32'h0);
        chk("bb_c5_data_ok", data_ok0, 1);
        chk("bb_c5_rdata", rdata0, 32'h44444444);
        chk("bb_c5_data_ok1", data_ok1, 0);
        tick(0, 0, 32'h0, 4'h0, 32'h0);

        // Partial write then read of the same word
        tick(1, 1, 32'h00000008, 4'b0011, 32'h12345678);
        chk("wr_mem_we", mem_we0, 4'b0011);
        chk("wr_mem_wdata", mem_wdata0, 32'h12345678);
        chk("wr_mem_addr", mem_addr0, 12'h002);
        tick(1, 0, 32'h00000008, 4'h0, 32'h0);
        chk("wr_rd_addr_ok", addr_ok0, 1);
        chk("wr_l1_data_ok", data_ok1, 1);
        chk("wr_l1_rdata", rdata1, 0);
        tick(0, 0, 32'h0, 4'h0, 32'h0);
        chk("wr_rsp_data_ok", data_ok0, 1);
        chk("wr_rsp_rdata", rdata0, 0);
        chk("wr_l1_rd_rdata", rdata1, 32'hAAAA5678);
        tick(0, 0, 32'h0, 4'h0, 32'h0);
        chk("wr_rd_data_ok", data_ok0, 1);
        chk("wr_rd_rdata", rdata0, 32'hAAAA5678);
        tick(0, 0, 32'h0, 4'h0, 32'h0);
        chk("wr_idle_data_ok", data_ok0, 0);

        // Reset with two reads in flight
        tick(1, 0, 32'h00000014, 4'h0, 32'h0);
        tick(1, 0, 32'h00000000, 4'h0, 32'h0);
        chk("mr_second_accept", addr_ok0, 1);
        @(posedge clk);
        #1;
        reset = 1'b1; req = 1'b0;
        @(negedge clk);
        chk("mr_rst_data_ok", data_ok0, 0);
        chk("mr_rst_rdata", rdata0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mr_post1_data_ok", data_ok0, 0);
        tick(0, 0, 32'h0, 4'h0, 32'h0);
        chk("mr_post2_data_ok", data_ok0, 0);
        tick(1, 0, 32'h00000008, 4'h0, 32'h0);
        chk("mr_new_addr_ok", addr_ok0, 1);
        tick(0, 0, 32'h0, 4'h0, 32'h0);
        chk("mr_new_t1_data_ok", data_ok0, 0);
        chk("mr_new_l1_rdata", rdata1, 32'hAAAA5678);
        tick(0, 0, 32'h0, 4'h0, 32'h0);
        chk("mr_new_data_ok", data_ok0, 1);
        chk("mr_new_rdata", rdata0, 32'hAAAA5678);
        tick(0, 0, 32'h0, 4'h0, 32'h0);

        // Random traffic with stall against a reference memory and response queue
        for (int i = 0; i < 16; i++) refmem[i] = ram0[i];
        acc = 0;
        cyc = 0;
        while (acc < 1000 && cyc < 6000) begin
            cyc++;
            @(posedge clk);
            #1;
            a_rand = $urandom();
            a_rand[13:2] = 12'($urandom_range(0, 15));
            req   = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 9) < 3);
            wr    = $urandom_range(0, 1) == 1;
            wstrb = 4'($urandom_range(0, 15));
            wdata = $urandom();
            addr  = a_rand;
            @(negedge clk);
            outstanding = sb.size();
            chk("rnd_addr_ok", addr_ok0, {31'b0, req & ~stall & (outstanding < 2)});
            if (data_ok0) begin
                if (sb.size() == 0) chk("rnd_spurious", data_ok0, 0);
                else begin
                    exp_val = sb.pop_front();
                    chk("rnd_rdata", rdata0, exp_val);
                end
            end
            if (addr_ok0) begin
                acc++;
                if (wr) begin
                    sb.push_back(32'h0);
                    w_rand = refmem[addr[5:2]];
                    for (int b = 0; b < 4; b++)
                        if (wstrb[b]) w_rand[8*b +: 8] = wdata[8*b +: 8];
                    refmem[addr[5:2]] = w_rand;
                end else begin
                    sb.push_back(refmem[addr[5:2]]);
                end
            end
            chk("rnd_depth", {31'b0, sb.size() <= 2}, 1);
        end
        chk("rnd_budget", acc, 1000);
        stall = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick(0, 0, 32'h0, 4'h0, 32'h0);
            if (data_ok0) begin
                if (sb.size() == 0) chk("drain_spurious", data_ok0, 0);
                else begin
                    exp_val = sb.pop_front();
                    chk("drain_rdata", rdata0, exp_val);
                end
            end
        end
        chk("drain_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
